tqvp_bus_master: RTL

Bus initiator for the TinyQV peripheral interface, and the other end of the link that FPU-style peripherals implement. It accepts single read/write commands on a valid/ready command port and drives a peripheral's `address`, `data_in`, `data_write_n` and `data_read_n` pins. For reads it waits for `data_ready` and returns the size-masked `data_out` on a valid/ready response port. It serves as the stand-in host for peripheral benches and as the sequencer in standalone peripheral harnesses.

---
 rtl/tqvp_bus_pkg.sv | 26 ++
 rtl/tqvp_bus_timer.sv | 37 +++
 rtl/tqvp_bus_master.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/tqvp_bus_pkg.sv
// Shared types for the TinyQV peripheral bus master: size codes, FSM states and read-data masking.
package tqvp_bus_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;
   localparam logic [1:0] SIZE_NONE = 2'b11;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITE     = 2'd1,
      READ_WAIT = 2'd2,
      RESP      = 2'd3
   } bus_state_e;

   // Zero-extends the addressed lanes of a peripheral read; an illegal size yields 0.
   function automatic logic [31:0] size_mask(input logic [1:0] size, input logic [31:0] data);
      case (size)
         SIZE_BYTE: return {24'h0, data[7:0]};
         SIZE_HALF: return {16'h0, data[15:0]};
         SIZE_WORD: return data;
         default:   return 32'h0;
      endcase
   endfunction

endpackage

// File: rtl/tqvp_bus_timer.sv
// Read-wait counter for the bus master; only built when TQVP_BUS_TIMEOUT_EN is defined.
module tqvp_bus_timer #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] count_q;
   logic [7:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = 8'h0;
      end else if (enable) begin
         count_d = count_q + 8'h1;
      end
   end

   // Expire fires during the wait cycle that brings the count up to TIMEOUT_CYCLES.
   assign expire = enable && (count_q == LAST_COUNT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= 8'h0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/tqvp_bus_master.sv
// Single-command initiator for the TinyQV peripheral bus; define TQVP_BUS_TIMEOUT_EN to abort stalled reads.
module tqvp_bus_master
   import tqvp_bus_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [1:0]  cmd_size,
   input  logic [5:0]  cmd_addr,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [5:0]  address,
   output logic [31:0] data_in,
   output logic [1:0]  data_write_n,
   output logic [1:0]  data_read_n,
   input  logic [31:0] data_out,
   input  logic        data_ready
);

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("tqvp_bus_master: TIMEOUT_CYCLES must be in 1..255");
   end

   bus_state_e  state_q, state_d;
   logic [1:0]  size_q, size_d;
   logic [5:0]  address_q, address_d;
   logic [31:0] data_in_q, data_in_d;
   logic [1:0]  write_n_q, write_n_d;
   logic [1:0]  read_n_q, read_n_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_err_q, rsp_err_d;
   logic        timer_clear;
   logic        timeout_c;

`ifdef TQVP_BUS_TIMEOUT_EN
   tqvp_bus_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clear  (timer_clear),
      .enable ((state_q == READ_WAIT) && !data_ready),
      .expire (timeout_c)
   );
`else
   assign timeout_c = 1'b0;
`endif

   // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
   always_comb begin
      state_d     = state_q;
      size_d      = size_q;
      address_d   = address_q;
      data_in_d   = data_in_q;
      write_n_d   = SIZE_NONE;
      read_n_d    = SIZE_NONE;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      timer_clear = 1'b0;

      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               address_d = cmd_addr;
               data_in_d = cmd_wdata;
               size_d    = cmd_size;
               if (cmd_size == SIZE_NONE) begin
                  state_d     = RESP;
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = 32'h0;
               end else if (cmd_write) begin
                  state_d   = WRITE;
                  write_n_d = cmd_size;
               end else begin
                  state_d     = READ_WAIT;
                  read_n_d    = cmd_size;
                  timer_clear = 1'b1;
               end
            end
         end
         WRITE: begin
            state_d     = RESP;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = 32'h0;
         end
         READ_WAIT: begin
            // data_ready takes priority over a timeout landing on the same cycle.
            if (data_ready) begin
               state_d     = RESP;
               rsp_err_d   = 1'b0;
               rsp_rdata_d = size_mask(size_q, data_out);
            end else if (timeout_c) begin
               state_d     = RESP;
               rsp_err_d   = 1'b1;
               rsp_rdata_d = 32'h0;
            end else begin
               read_n_d = size_q;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         size_q      <= SIZE_NONE;
         address_q   <= 6'h0;
         data_in_q   <= 32'h0;
         write_n_q   <= SIZE_NONE;
         read_n_q    <= SIZE_NONE;
         rsp_rdata_q <= 32'h0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         size_q      <= size_d;
         address_q   <= address_d;
         data_in_q   <= data_in_d;
         write_n_q   <= write_n_d;
         read_n_q    <= read_n_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign cmd_ready    = (state_q == IDLE) && !rst;
   assign rsp_valid    = (state_q == RESP);
   assign rsp_rdata    = rsp_rdata_q;
   assign rsp_err      = rsp_err_q;
   assign address      = address_q;
   assign data_in      = data_in_q;
   assign data_write_n = write_n_q;
   assign data_read_n  = read_n_q;

endmodule
